// File: rtl/csr_pkg.sv
// Shared CSR-file definitions for the trap controller: CSR indices, mstatus
// field positions, mstatus reset value, FSM state encoding and the mstatus update rule.
package csr_pkg;

    localparam int unsigned CSR_MCAUSE  = 0;
    localparam int unsigned CSR_MSTATUS = 1;
    localparam int unsigned CSR_MEPC    = 2;
    localparam int unsigned CSR_MTVEC   = 3;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        W_EPC,
        W_CAUSE,
        W_STAT,
        R_VEC,
        R_EPC,
        RDIR
    } state_e;

    // Trap entry stacks MIE into MPIE and enters M-mode; mret unstacks it and drops to U-mode.
    function automatic logic [63:0] mstatus_update(input logic [63:0] cur, input logic ecall);
        logic [63:0] nxt;
        nxt = cur;
        if (ecall) begin
            nxt[MSTATUS_MPIE]                  = cur[MSTATUS_MIE];
            nxt[MSTATUS_MIE]                   = 1'b0;
            nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else begin
            nxt[MSTATUS_MIE]                   = cur[MSTATUS_MPIE];
            nxt[MSTATUS_MPIE]                  = 1'b1;
            nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of the trap request/redirect handshake, the CSR-instruction port and the
// CSR-file port seen by trap_ctrl; master is the core/CSR-file side, slave is trap_ctrl.
interface trap_ctrl_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 64
);
    logic                  trap_req;
    logic                  trap_ecall;
    logic                  trap_mret;
    logic [63:0]           trap_pc;
    logic [63:0]           trap_cause;
    logic                  trap_ack;

    logic                  csr_wreq;
    logic [ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0] csr_wdata;
    logic                  csr_wgnt;
    logic [ADDR_WIDTH-1:0] csr_raddr;

    logic [ADDR_WIDTH-1:0] csrf_raddr;
    logic [DATA_WIDTH-1:0] csrf_rdata;
    logic [ADDR_WIDTH-1:0] csrf_waddr;
    logic [DATA_WIDTH-1:0] csrf_wdata;
    logic                  csrf_wen;

    logic                  redirect_vld;
    logic [63:0]           redirect_pc;
    logic                  busy;

    modport master (
        output trap_req, trap_ecall, trap_mret, trap_pc, trap_cause,
        output csr_wreq, csr_waddr, csr_wdata, csr_raddr, csrf_rdata,
        input  trap_ack, csr_wgnt, csrf_raddr, csrf_waddr, csrf_wdata, csrf_wen,
        input  redirect_vld, redirect_pc, busy
    );

    modport slave (
        input  trap_req, trap_ecall, trap_mret, trap_pc, trap_cause,
        input  csr_wreq, csr_waddr, csr_wdata, csr_raddr, csrf_rdata,
        output trap_ack, csr_wgnt, csrf_raddr, csrf_waddr, csrf_wdata, csrf_wen,
        output redirect_vld, redirect_pc, busy
    );

endinterface

// File: rtl/csrf_wr_arb.sv
// CSR-file write port arbiter: the trap FSM owns the port except in IDLE with no
// pending trap, where a CSR-instruction write is passed straight through.
module csrf_wr_arb #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  rst,
    input  logic                  idle,
    input  logic                  trap_req,
    input  logic                  csr_wreq,
    input  logic [ADDR_WIDTH-1:0] csr_waddr,
    input  logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic                  fsm_wen,
    input  logic [ADDR_WIDTH-1:0] fsm_waddr,
    input  logic [DATA_WIDTH-1:0] fsm_wdata,
    output logic                  csr_wgnt,
    output logic                  csrf_wen,
    output logic [ADDR_WIDTH-1:0] csrf_waddr,
    output logic [DATA_WIDTH-1:0] csrf_wdata
);

    // A trap request in the same IDLE cycle takes priority over the instruction write.
    assign csr_wgnt   = csr_wreq & idle & ~trap_req & ~rst;
    assign csrf_wen   = csr_wgnt | fsm_wen;
    assign csrf_waddr = csr_wgnt ? csr_waddr : fsm_waddr;
    assign csrf_wdata = csr_wgnt ? csr_wdata : fsm_wdata;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer driving a 4-entry CSR file.
// Define TRAP_CTRL_VECTORED_EN to enable vectored mtvec dispatch for interrupt causes.
module trap_ctrl
    import csr_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 64
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);

    state_e                state;
    state_e                state_nx;
    logic                  is_ecall;
    logic                  is_redir;
    logic [63:0]           cap_pc;
    logic [63:0]           cap_cause;
    logic [63:0]           redirect_pc_q;
    logic [63:0]           vec_target;
    logic                  idle;
    logic                  fsm_wen;
    logic [ADDR_WIDTH-1:0] fsm_waddr;
    logic [ADDR_WIDTH-1:0] fsm_raddr;
    logic [DATA_WIDTH-1:0] fsm_wdata;
    logic                  ack;
    logic                  redir;

    assign idle = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT;
            is_ecall      <= 1'b0;
            is_redir      <= 1'b0;
            cap_pc        <= '0;
            cap_cause     <= '0;
            redirect_pc_q <= '0;
        end else begin
            state <= state_nx;
            if (idle && bus.trap_req) begin
                is_ecall <= bus.trap_ecall;
                is_redir <= bus.trap_ecall | bus.trap_mret;
                if (bus.trap_ecall) begin
                    cap_pc    <= bus.trap_pc;
                    cap_cause <= bus.trap_cause;
                end
            end
            if (state == R_VEC) redirect_pc_q <= vec_target;
            if (state == R_EPC) redirect_pc_q <= 64'(bus.csrf_rdata);
        end
    end

    always_comb begin
        vec_target = {bus.csrf_rdata[63:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
        if (bus.csrf_rdata[1:0] == 2'b01 && cap_cause[63]) begin
            vec_target = vec_target + {cap_cause[61:0], 2'b00};
        end
`endif
    end

    always_comb begin
        state_nx  = state;
        fsm_wen   = 1'b0;
        fsm_waddr = '0;
        fsm_wdata = '0;
        fsm_raddr = '0;
        ack       = 1'b0;
        redir     = 1'b0;
        case (state)
            INIT: begin
                fsm_wen   = 1'b1;
                fsm_waddr = ADDR_WIDTH'(CSR_MSTATUS);
                fsm_wdata = DATA_WIDTH'(MSTATUS_RST);
                state_nx  = IDLE;
            end
            IDLE: begin
                if (bus.trap_req) begin
                    if (bus.trap_ecall)     state_nx = W_EPC;
                    else if (bus.trap_mret) state_nx = R_EPC;
                    else                    state_nx = RDIR;
                end
            end
            W_EPC: begin
                fsm_wen   = 1'b1;
                fsm_waddr = ADDR_WIDTH'(CSR_MEPC);
                fsm_wdata = DATA_WIDTH'(cap_pc);
                state_nx  = W_CAUSE;
            end
            W_CAUSE: begin
                fsm_wen   = 1'b1;
                fsm_waddr = ADDR_WIDTH'(CSR_MCAUSE);
                fsm_wdata = DATA_WIDTH'(cap_cause);
                state_nx  = W_STAT;
            end
            W_STAT: begin
                fsm_raddr = ADDR_WIDTH'(CSR_MSTATUS);
                fsm_wen   = 1'b1;
                fsm_waddr = ADDR_WIDTH'(CSR_MSTATUS);
                fsm_wdata = DATA_WIDTH'(mstatus_update(64'(bus.csrf_rdata), is_ecall));
                state_nx  = is_ecall ? R_VEC : RDIR;
            end
            R_VEC: begin
                fsm_raddr = ADDR_WIDTH'(CSR_MTVEC);
                state_nx  = RDIR;
            end
            R_EPC: begin
                fsm_raddr = ADDR_WIDTH'(CSR_MEPC);
                state_nx  = W_STAT;
            end
            RDIR: begin
                ack      = 1'b1;
                redir    = is_redir;
                state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
        // Reset aborts the sequence immediately, suppressing this cycle's write and strobes.
        if (rst) begin
            fsm_wen = 1'b0;
            ack     = 1'b0;
            redir   = 1'b0;
        end
    end

    csrf_wr_arb #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_arb (
        .rst        (rst),
        .idle       (idle),
        .trap_req   (bus.trap_req),
        .csr_wreq   (bus.csr_wreq),
        .csr_waddr  (bus.csr_waddr),
        .csr_wdata  (bus.csr_wdata),
        .fsm_wen    (fsm_wen),
        .fsm_waddr  (fsm_waddr),
        .fsm_wdata  (fsm_wdata),
        .csr_wgnt   (bus.csr_wgnt),
        .csrf_wen   (bus.csrf_wen),
        .csrf_waddr (bus.csrf_waddr),
        .csrf_wdata (bus.csrf_wdata)
    );

    assign bus.csrf_raddr   = idle ? bus.csr_raddr : fsm_raddr;
    assign bus.trap_ack     = ack;
    assign bus.redirect_vld = redir;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.busy         = ~idle;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 2, CSR file index width; DATA_WIDTH, 64, CSR data width.
REQ-002 SHALL have these ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- trap_req  in  1  trap/return request, held until trap_ack
- trap_ecall  in  1  request is ecall
- trap_mret  in  1  request is mret
- trap_pc  in  64  PC of trapping instruction
- trap_cause  in  64  mcause value
- trap_ack  out  1  request retired
- csr_wreq  in  1  CSR-instruction write request
- csr_waddr  in  ADDR_WIDTH  CSR-instruction write index
- csr_wdata  in  DATA_WIDTH  CSR-instruction write data
- csr_wgnt  out  1  CSR-instruction write performed this cycle
- csr_raddr  in  ADDR_WIDTH  CSR-instruction read index
- csrf_raddr  out  ADDR_WIDTH  CSR file read index (asynchronous read)
- csrf_rdata  in  DATA_WIDTH  CSR file read data
- csrf_waddr  out  ADDR_WIDTH  CSR file write index
- csrf_wdata  out  DATA_WIDTH  CSR file write data
- csrf_wen  out  1  CSR file write enable
- redirect_vld  out  1  one-cycle PC redirect strobe
- redirect_pc  out  64  redirect target
- busy  out  1  high in every state except IDLE

Function
REQ-003 CSR indices SHALL be: mcause=0, mstatus=1, mepc=2, mtvec=3.
REQ-004 FSM states SHALL be: INIT, IDLE, W_EPC, W_CAUSE, W_STAT, R_VEC, R_EPC, RDIR.
REQ-005 INIT SHALL write mstatus=64'h0000_000A_0000_1800 for one cycle, then go to IDLE.
REQ-006 IDLE with trap_req&trap_ecall SHALL capture trap_pc/trap_cause into registers and go to W_EPC; ecall wins if both ecall and mret asserted.
REQ-007 IDLE with trap_req&trap_mret&~trap_ecall SHALL go to R_EPC.
REQ-008 IDLE with trap_req and neither flag SHALL go to RDIR with no CSR writes and redirect_vld held 0.
REQ-009 Ecall path SHALL be W_EPC (mepc<=captured pc) -> W_CAUSE (mcause<=captured cause) -> W_STAT -> R_VEC (capture mtvec) -> RDIR -> IDLE.
REQ-010 Mret path SHALL be R_EPC (capture mepc) -> W_STAT -> RDIR -> IDLE.
REQ-011 W_STAT SHALL read mstatus and write back same cycle: ecall: MPIE[7]<=MIE[3], MIE<=0, MPP[12:11]<=2'b11; mret: MIE<=MPIE, MPIE<=1, MPP<=2'b00; other bits unchanged.
REQ-012 RDIR SHALL assert trap_ack=1 and redirect_vld=1 (except REQ-008) for exactly one cycle.
REQ-013 Redirect target SHALL be {mtvec[63:2],2'b00} for ecall and the captured mepc for mret.
REQ-014 Latency: ecall accepted at edge T SHALL give redirect_vld in the 5th cycle after T; mret in the 3rd.
REQ-015 csr_wgnt SHALL be csr_wreq & state==IDLE & ~trap_req; when granted csrf_wen/waddr/wdata SHALL pass csr_* through combinationally.
REQ-016 Trap sequence SHALL have priority: simultaneous trap_req and csr_wreq in IDLE SHALL grant the trap and hold csr_wgnt=0.
REQ-017 In IDLE csrf_raddr SHALL equal csr_raddr; in other states it SHALL be the FSM's read index.
REQ-018 trap_req while busy SHALL be ignored until the FSM returns to IDLE.
REQ-019 csrf_wen SHALL be 0 in IDLE without grant, R_VEC, R_EPC and RDIR.

Reset
REQ-020 rst SHALL force state=INIT, trap_ack=0, redirect_vld=0, csr_wgnt=0, redirect_pc=0, captured registers=0.
REQ-021 rst mid-sequence SHALL abort it with no redirect; remaining CSR writes SHALL NOT be issued.

Configuration
REQ-022 Macro TRAP_CTRL_VECTORED_EN defined: ecall with mtvec[1:0]==2'b01 and trap_cause[63]==1 SHALL redirect to {mtvec[63:2],2'b00}+4*cause[61:0]; undefined: always direct mode (REQ-013).

Structure
REQ-023 CSR index constants, mstatus bit positions, reset value and the FSM state enum SHALL live in shared package csr_pkg.
REQ-024 Arbitration (REQ-015/016) SHALL be sub-module csrf_wr_arb; FSM stays in trap_ctrl.

Verification
REQ-025 Reset release -> one INIT write mstatus=64'hA_0000_1800, then busy=0.
REQ-026 ecall pc=0x8000_0010 cause=0xB, mtvec=0x8000_0100 -> mepc=0x8000_0010, mcause=0xB, MIE cleared, redirect_pc=0x8000_0100 in 5th cycle.
REQ-027 mret, mepc=0x8000_0014, MPIE=1 -> MIE=1, redirect_pc=0x8000_0014 in 3rd cycle.
REQ-028 trap_req and csr_wreq same IDLE cycle -> csr_wgnt=0 until busy drops, then write granted.
REQ-029 rst asserted in W_CAUSE -> mcause unchanged, no redirect_vld, INIT re-entered.
REQ-030 VECTORED_EN, mtvec=0x8000_0101, cause=0x8000_0000_0000_0007 -> redirect_pc=0x8000_011C.
